// File: rtl/credit_pkg.sv
// Shared definitions for the multi-channel credit shell: credit counter
// width, error bit positions and the per-channel slice helper.
package credit_pkg;

  // Bit positions inside the sticky error vector.
  localparam int ERR_FULL   = 0;
  localparam int ERR_CREDIT = 1;

  // Width needed to hold a credit count in the range 0..n inclusive.
  function automatic int cred_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Low bit of channel c inside a flat bus of w-bit channel words.
  function automatic int chan_lsb(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/credit_chan_fifo.sv
// Per-channel first-word-fall-through FIFO. The head word is always visible
// on o_data while the FIFO is non-empty. A word written into an empty FIFO
// shows up at the head one cycle later (no bypass path). A write into a full
// FIFO is accepted only if a read happens in the same cycle; otherwise it is
// dropped and o_drop flags it for that cycle.
module credit_chan_fifo
  import credit_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int FIFO_ADDR  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_enq,
  input  logic                  i_deq,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_drop
);

  localparam int DEPTH = 2 ** FIFO_ADDR;
  localparam logic [FIFO_ADDR:0] FULL_COUNT = (FIFO_ADDR + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_ADDR-1:0]  rd_ptr;
  logic [FIFO_ADDR-1:0]  wr_ptr;
  logic [FIFO_ADDR:0]    count;
  logic                  do_deq;
  logic                  do_enq;

  // Decide which of the requested read/write actually take effect.
  always_comb begin
    o_empty = (count == '0);
    o_full  = (count == FULL_COUNT);
    do_deq  = i_deq && !o_empty;
    do_enq  = i_enq && (!o_full || do_deq);
    o_drop  = i_enq && o_full && !do_deq;
    o_data  = mem[rd_ptr];
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_enq) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/credit_shell_nch.sv
// Latency-insensitive shell joining N_CH credit-based input channels in
// front of a fixed-latency pearl.
//
// Flow control: upstream channel c may pulse i_valid[c] only while it holds
// a credit; each dequeued word returns one credit via a one-cycle pulse on
// o_increment_count[c] the cycle after the dequeue. Towards downstream the
// shell spends one credit at every fire, so o_valid (PEARL_LATENCY cycles
// later) never needs a ready; downstream hands credits back by pulsing
// i_increment_count. o_data is meaningful only while o_valid is high.
module credit_shell_nch
  import credit_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int DATA_WIDTH    = 17,
  parameter int FIFO_ADDR     = 3,
  parameter int N_CREDITS     = 8,
  parameter int PEARL_LATENCY = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_CH*DATA_WIDTH-1:0]       i_data,
  input  logic [N_CH-1:0]                  i_valid,
  output logic [N_CH-1:0]                  o_increment_count,
  output logic [N_CH*DATA_WIDTH-1:0]       o_pearl_data,
  output logic                             o_pearl_ena,
  input  logic [DATA_WIDTH-1:0]            i_pearl_data,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  input  logic                             i_increment_count,
  output logic [cred_w(N_CREDITS)-1:0]     o_credits,
  output logic [1:0]                       o_err
);

  localparam int CW = cred_w(N_CREDITS);
  localparam logic [CW-1:0] CRED_MAX = CW'(N_CREDITS);

  logic [N_CH-1:0]          empty;
  logic [N_CH-1:0]          full;
  logic [N_CH-1:0]          drop;
  logic                     fire;
  logic [CW-1:0]            credits_q;
  logic [CW-1:0]            credits_d;
  logic                     cred_ovf;
  logic [N_CH-1:0]          inc_q;
  logic [PEARL_LATENCY-1:0] vpipe_q;
  logic [1:0]               err_q;

  // One FIFO per channel; all of them are popped together on fire.
  for (genvar c = 0; c < N_CH; c++) begin : g_chan
    credit_chan_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_ADDR  (FIFO_ADDR)
    ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_data  (i_data[chan_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
      .i_enq   (i_valid[c]),
      .i_deq   (fire),
      .o_data  (o_pearl_data[chan_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
      .o_empty (empty[c]),
      .o_full  (full[c]),
      .o_drop  (drop[c])
    );
  end

  // Join: fire only when every channel has a head word and downstream has room.
  always_comb begin
    fire = (&(~empty)) && (credits_q != '0);
  end

  // Next credit count; a return at the ceiling with no spend saturates and flags.
  always_comb begin
    credits_d = credits_q;
    cred_ovf  = 1'b0;
    case ({fire, i_increment_count})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == CRED_MAX) cred_ovf = 1'b1;
        else                       credits_d = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  // Credit counter, upstream credit returns, valid pipe and sticky errors.
  always_ff @(posedge clock) begin
    if (!reset) begin
      credits_q <= CRED_MAX;
      inc_q     <= '0;
      vpipe_q   <= '0;
      err_q     <= '0;
    end else begin
      credits_q         <= credits_d;
      inc_q             <= {N_CH{fire}};
      vpipe_q           <= PEARL_LATENCY'({vpipe_q, fire});
      err_q[ERR_FULL]   <= err_q[ERR_FULL] | (|drop);
      err_q[ERR_CREDIT] <= err_q[ERR_CREDIT] | cred_ovf;
    end
  end

  // Output drive.
  always_comb begin
    o_pearl_ena       = fire;
    o_increment_count = inc_q;
    o_valid           = vpipe_q[PEARL_LATENCY-1];
    o_data            = i_pearl_data;
    o_credits         = credits_q;
    o_err             = err_q;
  end

endmodule

// File: tb/tb_credit_shell_nch.sv
// Bench for credit_shell_nch: directed scenarios plus a randomized run
// checked against a queue-based reference model and a stand-in pearl.
module tb_credit_shell_nch;
  import credit_pkg::*;

  localparam int N_CH  = 2;
  localparam int DW    = 17;
  localparam int FA    = 3;
  localparam int DEPTH = 2 ** FA;
  localparam int NC    = 8;
  localparam int PL    = 1;
  localparam int CW    = cred_w(NC);

  // ---------------- clock / reset / DUT ----------------
  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [N_CH*DW-1:0]   i_data = '0;
  logic [N_CH-1:0]      i_valid = '0;
  logic                 i_increment_count = 1'b0;
  logic [N_CH-1:0]      o_increment_count;
  logic [N_CH*DW-1:0]   o_pearl_data;
  logic                 o_pearl_ena;
  logic [DW-1:0]        i_pearl_data;
  logic [DW-1:0]        o_data;
  logic                 o_valid;
  logic [CW-1:0]        o_credits;
  logic [1:0]           o_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  credit_shell_nch #(
    .N_CH(N_CH), .DATA_WIDTH(DW), .FIFO_ADDR(FA),
    .N_CREDITS(NC), .PEARL_LATENCY(PL)
  ) dut (
    .clock(clock), .reset(reset), .i_data(i_data), .i_valid(i_valid),
    .o_increment_count(o_increment_count), .o_pearl_data(o_pearl_data),
    .o_pearl_ena(o_pearl_ena), .i_pearl_data(i_pearl_data), .o_data(o_data),
    .o_valid(o_valid), .i_increment_count(i_increment_count),
    .o_credits(o_credits), .o_err(o_err)
  );

  // Stand-in pearl: a fixed function of all channel words, PL cycles deep.
  function automatic logic [DW-1:0] pearl_fn(input logic [N_CH*DW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int c = N_CH - 1; c >= 0; c--) r = ((r << 1) + r) ^ v[c*DW +: DW];
    return r;
  endfunction

  logic [DW-1:0] pearl_pipe [PL];
  always @(posedge clock) begin
    pearl_pipe[0] <= pearl_fn(o_pearl_data);
    for (int i = 1; i < PL; i++) pearl_pipe[i] <= pearl_pipe[i-1];
  end
  assign i_pearl_data = pearl_pipe[PL-1];

  // ---------------- reference model ----------------
  logic [DW-1:0]   mq [N_CH][$];
  int              m_credits = NC;
  logic [1:0]      m_err = '0;
  logic [N_CH-1:0] m_inc = '0;
  int              cyc = 0;
  int              due_q[$];
  logic [DW-1:0]   exp_q[$];

  function automatic logic m_fire_now();
    logic ok;
    ok = (m_credits > 0);
    for (int c = 0; c < N_CH; c++) if (mq[c].size() == 0) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [N_CH*DW-1:0] m_heads();
    logic [N_CH*DW-1:0] h;
    h = '0;
    for (int c = 0; c < N_CH; c++) if (mq[c].size() != 0) h[c*DW +: DW] = mq[c][0];
    return h;
  endfunction

  function automatic logic m_valid_now();
    return (due_q.size() != 0) && (due_q[0] == cyc);
  endfunction

  always @(posedge clock) begin : ref_model
    logic f;
    logic [N_CH*DW-1:0] h;
    cyc++;
    while (due_q.size() != 0 && due_q[0] < cyc) begin
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
    end
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) mq[c].delete();
      m_credits = NC;
      m_err = '0;
      m_inc = '0;
      due_q.delete();
      exp_q.delete();
    end else begin
      f = m_fire_now();
      h = m_heads();
      if (f) begin
        due_q.push_back(cyc + PL - 1);
        exp_q.push_back(pearl_fn(h));
      end
      for (int c = 0; c < N_CH; c++) begin
        if (f) void'(mq[c].pop_front());
        if (i_valid[c]) begin
          if (mq[c].size() < DEPTH) mq[c].push_back(i_data[c*DW +: DW]);
          else m_err[0] = 1'b1;
        end
      end
      m_inc = f ? '1 : '0;
      if (i_increment_count && !f && m_credits == NC) m_err[1] = 1'b1;
      else m_credits = m_credits - (f ? 1 : 0) + (i_increment_count ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_valid = '0;
    i_increment_count = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_credits !== CW'(NC)) begin n_bad++; $display("FAIL reset_credits got %0d want %0d", o_credits, NC); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_cmp++; if (o_err !== 2'b00) begin n_bad++; $display("FAIL reset_err got %b want 00", o_err); end
    n_cmp++; if (o_increment_count !== '0) begin n_bad++; $display("FAIL reset_inc got %b want 00", o_increment_count); end
    n_cmp++; if (o_pearl_ena !== 1'b0) begin n_bad++; $display("FAIL reset_ena got %b want 0", o_pearl_ena); end
  endtask

  task automatic test_basic();
    logic [N_CH*DW-1:0] pair;
    do_reset();
    pair = {17'h0000B, 17'h0000A};
    i_valid = 2'b11;
    i_data = pair;
    tick();
    i_valid = '0;
    n_cmp++; if (o_pearl_ena !== 1'b1) begin n_bad++; $display("FAIL basic_ena got %b want 1", o_pearl_ena); end
    n_cmp++; if (o_pearl_data !== pair) begin n_bad++; $display("FAIL basic_pearl_data got %h want %h", o_pearl_data, pair); end
    n_cmp++; if (o_credits !== CW'(8)) begin n_bad++; $display("FAIL basic_credits_pre got %0d want 8", o_credits); end
    tick();
    n_cmp++; if (o_increment_count !== 2'b11) begin n_bad++; $display("FAIL basic_inc got %b want 11", o_increment_count); end
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", o_valid); end
    n_cmp++; if (o_credits !== CW'(7)) begin n_bad++; $display("FAIL basic_credits got %0d want 7", o_credits); end
    n_cmp++; if (o_data !== pearl_fn(pair)) begin n_bad++; $display("FAIL basic_data got %h want %h", o_data, pearl_fn(pair)); end
    tick();
    n_cmp++; if (o_increment_count !== 2'b00) begin n_bad++; $display("FAIL basic_inc_end got %b want 00", o_increment_count); end
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_end got %b want 0", o_valid); end
  endtask

  task automatic test_join_skew();
    logic [DW-1:0] w0 [3];
    logic [DW-1:0] w1 [3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      w0[k] = DW'($urandom);
      w1[k] = DW'($urandom);
    end
    for (int t = 0; t < 8; t++) begin
      i_valid = '0;
      i_data = '0;
      if (t < 3) begin i_valid[0] = 1'b1; i_data[0 +: DW] = w0[t]; end
      if (t >= 5) begin i_valid[1] = 1'b1; i_data[DW +: DW] = w1[t-5]; end
      tick();
      i_valid = '0;
      if (t < 5) begin
        n_cmp++; if (o_pearl_ena !== 1'b0) begin n_bad++; $display("FAIL skew_early_fire t=%0d got %b want 0", t, o_pearl_ena); end
      end else begin
        n_cmp++; if (o_pearl_ena !== 1'b1) begin n_bad++; $display("FAIL skew_fire t=%0d got %b want 1", t, o_pearl_ena); end
        n_cmp++; if (o_pearl_data !== {w1[t-5], w0[t-5]}) begin n_bad++; $display("FAIL skew_pair t=%0d got %h want %h", t, o_pearl_data, {w1[t-5], w0[t-5]}); end
      end
      if (t >= 6) begin
        n_cmp++; if (o_valid !== 1'b1 || o_data !== pearl_fn({w1[t-6], w0[t-6]})) begin n_bad++; $display("FAIL skew_out t=%0d got v=%b d=%h want v=1 d=%h", t, o_valid, o_data, pearl_fn({w1[t-6], w0[t-6]})); end
      end
    end
    tick();
    n_cmp++; if (o_pearl_ena !== 1'b0) begin n_bad++; $display("FAIL skew_drained got %b want 0", o_pearl_ena); end
    n_cmp++; if (o_valid !== 1'b1 || o_data !== pearl_fn({w1[2], w0[2]})) begin n_bad++; $display("FAIL skew_last_out got v=%b d=%h want v=1 d=%h", o_valid, o_data, pearl_fn({w1[2], w0[2]})); end
    tick();
    n_cmp++; if (o_credits !== CW'(5)) begin n_bad++; $display("FAIL skew_credits got %0d want 5", o_credits); end
  endtask

  task automatic test_credit_exhaustion();
    logic [DW-1:0] c0 [$];
    logic [DW-1:0] c1 [$];
    int fires;
    do_reset();
    fires = 0;
    for (int k = 0; k < 10; k++) begin
      c0.push_back(DW'($urandom));
      c1.push_back(DW'($urandom));
      i_valid = 2'b11;
      i_data = {c1[k], c0[k]};
      tick();
      if (o_pearl_ena) fires++;
    end
    i_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_pearl_ena) fires++;
    end
    n_cmp++; if (fires != 8) begin n_bad++; $display("FAIL exhaust_fires got %0d want 8", fires); end
    n_cmp++; if (o_credits !== CW'(0)) begin n_bad++; $display("FAIL exhaust_credits got %0d want 0", o_credits); end
    i_increment_count = 1'b1;
    tick();
    i_increment_count = 1'b0;
    n_cmp++; if (o_pearl_ena !== 1'b1 || o_pearl_data !== {c1[8], c0[8]}) begin n_bad++; $display("FAIL exhaust_one_more got ena=%b d=%h want ena=1 d=%h", o_pearl_ena, o_pearl_data, {c1[8], c0[8]}); end
    fires = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (o_pearl_ena) fires++;
    end
    n_cmp++; if (fires != 0) begin n_bad++; $display("FAIL exhaust_extra_fires got %0d want 0", fires); end
    i_increment_count = 1'b1;
    tick();
    i_increment_count = 1'b0;
    n_cmp++; if (o_pearl_ena !== 1'b1 || o_pearl_data !== {c1[9], c0[9]}) begin n_bad++; $display("FAIL exhaust_tenth got ena=%b d=%h want ena=1 d=%h", o_pearl_ena, o_pearl_data, {c1[9], c0[9]}); end
  endtask

  task automatic test_fire_and_inc();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      i_valid = 2'b11;
      i_data = {DW'($urandom), DW'($urandom)};
      tick();
    end
    i_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    n_cmp++; if (o_credits !== CW'(3)) begin n_bad++; $display("FAIL simul_setup_credits got %0d want 3", o_credits); end
    i_valid = 2'b11;
    i_data = {DW'($urandom), DW'($urandom)};
    tick();
    i_valid = '0;
    i_increment_count = 1'b1;
    n_cmp++; if (o_pearl_ena !== 1'b1) begin n_bad++; $display("FAIL simul_ena got %b want 1", o_pearl_ena); end
    tick();
    i_increment_count = 1'b0;
    n_cmp++; if (o_credits !== CW'(3)) begin n_bad++; $display("FAIL simul_credits got %0d want 3", o_credits); end
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL simul_valid got %b want 1", o_valid); end
  endtask

  task automatic test_credit_overflow();
    do_reset();
    i_increment_count = 1'b1;
    tick();
    i_increment_count = 1'b0;
    n_cmp++; if (o_credits !== CW'(NC)) begin n_bad++; $display("FAIL ovf_credits got %0d want %0d", o_credits, NC); end
    n_cmp++; if (o_err !== 2'b10) begin n_bad++; $display("FAIL ovf_err got %b want 10", o_err); end
    tick();
    n_cmp++; if (o_err !== 2'b10) begin n_bad++; $display("FAIL ovf_err_sticky got %b want 10", o_err); end
  endtask

  task automatic test_fifo_overflow();
    logic [DW-1:0] w [$];
    int got;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      i_valid = 2'b11;
      i_data = {DW'($urandom), DW'($urandom)};
      tick();
    end
    i_valid = '0;
    for (int k = 0; k < 3; k++) tick();
    n_cmp++; if (o_credits !== CW'(0)) begin n_bad++; $display("FAIL full_setup_credits got %0d want 0", o_credits); end
    for (int k = 0; k < 9; k++) begin
      w.push_back(DW'($urandom));
      i_valid = 2'b01;
      i_data = {DW'(0), w[k]};
      tick();
      if (k == 7) begin
        n_cmp++; if (o_err !== 2'b00) begin n_bad++; $display("FAIL full_err_early got %b want 00", o_err); end
      end
      if (k == 8) begin
        n_cmp++; if (o_err !== 2'b01) begin n_bad++; $display("FAIL full_err got %b want 01", o_err); end
      end
    end
    i_valid = '0;
    i_increment_count = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    i_increment_count = 1'b0;
    n_cmp++; if (o_credits !== CW'(8)) begin n_bad++; $display("FAIL full_restore_credits got %0d want 8", o_credits); end
    got = 0;
    for (int k = 0; k < 12; k++) begin
      i_valid = (k < 8) ? 2'b10 : 2'b00;
      i_data = {DW'($urandom), DW'(0)};
      tick();
      if (o_pearl_ena) begin
        if (got < 8) begin
          n_cmp++; if (o_pearl_data[0 +: DW] !== w[got]) begin n_bad++; $display("FAIL full_order idx=%0d got %h want %h", got, o_pearl_data[0 +: DW], w[got]); end
        end
        got++;
      end
    end
    i_valid = '0;
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL full_count got %0d want 8", got); end
    n_cmp++; if (o_err !== 2'b01) begin n_bad++; $display("FAIL full_err_final got %b want 01", o_err); end
  endtask

  task automatic test_reset_mid();
    logic [N_CH*DW-1:0] pair;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      i_valid = 2'b01;
      i_data = {DW'(0), DW'($urandom)};
      tick();
    end
    i_valid = 2'b10;
    i_data = {DW'($urandom), DW'(0)};
    tick();
    i_valid = 2'b01;
    i_data = {DW'(0), DW'($urandom)};
    tick();
    i_valid = '0;
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL mid_inflight got %b want 1", o_valid); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", o_valid); end
    n_cmp++; if (o_credits !== CW'(NC)) begin n_bad++; $display("FAIL mid_credits got %0d want %0d", o_credits, NC); end
    n_cmp++; if (o_err !== 2'b00) begin n_bad++; $display("FAIL mid_err got %b want 00", o_err); end
    n_cmp++; if (o_increment_count !== 2'b00) begin n_bad++; $display("FAIL mid_inc got %b want 00", o_increment_count); end
    n_cmp++; if (o_pearl_ena !== 1'b0) begin n_bad++; $display("FAIL mid_ena got %b want 0", o_pearl_ena); end
    tick();
    n_cmp++; if (o_increment_count !== 2'b00 || o_pearl_ena !== 1'b0) begin n_bad++; $display("FAIL mid_quiet got inc=%b ena=%b want 00/0", o_increment_count, o_pearl_ena); end
    pair = {DW'($urandom), DW'($urandom)};
    i_valid = 2'b11;
    i_data = pair;
    tick();
    i_valid = '0;
    n_cmp++; if (o_pearl_ena !== 1'b1 || o_pearl_data !== pair) begin n_bad++; $display("FAIL mid_after_fire got ena=%b d=%h want 1 %h", o_pearl_ena, o_pearl_data, pair); end
    tick();
    n_cmp++; if (o_valid !== 1'b1 || o_data !== pearl_fn(pair) || o_increment_count !== 2'b11) begin n_bad++; $display("FAIL mid_after_out got v=%b d=%h inc=%b want 1 %h 11", o_valid, o_data, o_increment_count, pearl_fn(pair)); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < N_CH; c++) begin
        i_valid[c] = ($urandom_range(0, 99) < 60);
        i_data[c*DW +: DW] = DW'($urandom);
      end
      i_increment_count = ($urandom_range(0, 99) < 45);
      tick();
      n_cmp++; if (o_pearl_ena !== m_fire_now()) begin n_bad++; $display("FAIL rnd_ena cyc=%0d got %b want %b", cyc, o_pearl_ena, m_fire_now()); end
      n_cmp++; if (o_credits !== CW'(m_credits)) begin n_bad++; $display("FAIL rnd_credits cyc=%0d got %0d want %0d", cyc, o_credits, m_credits); end
      n_cmp++; if (o_err !== m_err) begin n_bad++; $display("FAIL rnd_err cyc=%0d got %b want %b", cyc, o_err, m_err); end
      n_cmp++; if (o_increment_count !== m_inc) begin n_bad++; $display("FAIL rnd_inc cyc=%0d got %b want %b", cyc, o_increment_count, m_inc); end
      n_cmp++; if (o_valid !== m_valid_now()) begin n_bad++; $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, o_valid, m_valid_now()); end
      if (m_fire_now()) begin
        n_cmp++; if (o_pearl_data !== m_heads()) begin n_bad++; $display("FAIL rnd_heads cyc=%0d got %h want %h", cyc, o_pearl_data, m_heads()); end
      end
      if (m_valid_now()) begin
        n_cmp++; if (o_data !== exp_q[0]) begin n_bad++; $display("FAIL rnd_data cyc=%0d got %h want %h", cyc, o_data, exp_q[0]); end
      end
    end
    reset = 1'b1;
    i_valid = '0;
    i_increment_count = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_join_skew();
    test_credit_exhaustion();
    test_fire_and_inc();
    test_credit_overflow();
    test_fifo_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
